// File: rtl/icache_controller_pkg.sv
// Shared widths, FSM states and address-field helpers for the I-cache controller.
// ICACHE_FLUSH_EN adds the FLUSH state.
package icache_controller_pkg;

  localparam int AddrW      = 32;
  localparam int DataW      = 32;
  localparam int IndexW     = 10;
  localparam int CacheDepth = 1 << IndexW;
  localparam int TagW       = AddrW - IndexW - 2;

  typedef enum logic [2:0] {
    ST_LOOKUP,
    ST_MEM_REQ,
    ST_FILL,
    ST_RESUME
`ifdef ICACHE_FLUSH_EN
    ,
    ST_FLUSH
`endif
  } state_e;

  function automatic logic [IndexW-1:0] addr_index(
    input logic [AddrW-1:0] a
  );
    return a[IndexW+1:2];
  endfunction

  function automatic logic [TagW-1:0] addr_tag(
    input logic [AddrW-1:0] a
  );
    return a[AddrW-1 -: TagW];
  endfunction

endpackage

// File: rtl/icache_controller_hit_cmp.sv
// Valid-and-tag compare for the direct-mapped I-cache.
// Purely combinational.
module icache_hit_cmp
  import icache_controller_pkg::*;
#(
  parameter int TagWidth = TagW
) (
  input  logic                i_valid,
  input  logic [TagWidth-1:0] i_tag_rdata,
  input  logic [TagWidth-1:0] i_tag,
  output logic                o_hit
);

  assign o_hit = i_valid & (i_tag_rdata == i_tag);

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped I-cache controller: zero-wait hits, single-word refill.
// ICACHE_FLUSH_EN adds the flush port and the invalidate sweep.
module icache_controller
  import icache_controller_pkg::*;
#(
  parameter  int AddrWidth = AddrW,
  parameter  int DataWidth = DataW,
  localparam int TagWidth  = AddrWidth - IndexW - 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req,
  input  logic [AddrWidth-1:0] cpu_addr,
  output logic [DataWidth-1:0] cpu_instr,
  output logic                 cpu_stall,
  output logic [IndexW-1:0]    ram_index,
  output logic                 ram_write,
  output logic [TagWidth-1:0]  tag_wdata,
  input  logic [TagWidth-1:0]  tag_rdata,
  output logic                 valid_wdata,
  input  logic                 valid_rdata,
  output logic [DataWidth-1:0] data_wdata,
  input  logic [DataWidth-1:0] data_rdata,
  output logic                 mem_req,
  output logic [AddrWidth-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [DataWidth-1:0] mem_rdata
`ifdef ICACHE_FLUSH_EN
  ,
  input  logic                 flush
`endif
);

  state_e r_state;
  state_e w_next;

  logic [TagWidth-1:0]  r_tag;
  logic [IndexW-1:0]    r_index;
  logic [DataWidth-1:0] r_fill;

  logic [TagWidth-1:0]  w_tag;
  logic [IndexW-1:0]    w_index;
  logic                 w_hit;
  logic                 w_flush_go;
  logic                 w_unused_lsb;

  assign w_tag        = cpu_addr[AddrWidth-1 -: TagWidth];
  assign w_index      = cpu_addr[IndexW+1:2];
  assign w_unused_lsb = ^cpu_addr[1:0];

  icache_hit_cmp #(
    .TagWidth(TagWidth)
  ) u_hit_cmp (
    .i_valid    (valid_rdata),
    .i_tag_rdata(tag_rdata),
    .i_tag      (w_tag),
    .o_hit      (w_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOOKUP;
      r_tag   <= '0;
      r_index <= '0;
      r_fill  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_LOOKUP && w_next == ST_MEM_REQ) begin
        r_tag   <= w_tag;
        r_index <= w_index;
      end
      if (r_state == ST_MEM_REQ && mem_ack) begin
        r_fill <= mem_rdata;
      end
    end
  end

`ifdef ICACHE_FLUSH_EN
  logic              r_flush_pend;
  logic [IndexW:0]   r_flush_cnt;
  logic [IndexW-1:0] w_flush_idx;

  // Odd sweep cycles drop the strobe and move to the next index.
  assign w_flush_idx = r_flush_cnt[IndexW:1]
                     + IndexW'(r_flush_cnt[0]);
  assign w_flush_go  = flush | r_flush_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_pend <= 1'b0;
      r_flush_cnt  <= '0;
    end else begin
      if (r_state == ST_FLUSH) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end else begin
        r_flush_cnt <= '0;
      end
      if (r_state == ST_LOOKUP) begin
        r_flush_pend <= 1'b0;
      end else if (flush && r_state != ST_FLUSH) begin
        r_flush_pend <= 1'b1;
      end
    end
  end
`else
  assign w_flush_go = 1'b0;
`endif

  always_comb begin
    w_next      = r_state;
    cpu_stall   = 1'b0;
    cpu_instr   = '0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    ram_index   = '0;
    ram_write   = 1'b0;
    tag_wdata   = '0;
    valid_wdata = 1'b0;
    data_wdata  = '0;
    unique case (r_state)
      ST_LOOKUP: begin
        ram_index = w_index;
        if (w_flush_go) begin
          cpu_stall = cpu_req;
`ifdef ICACHE_FLUSH_EN
          w_next    = ST_FLUSH;
`endif
        end else if (cpu_req) begin
          if (w_hit) begin
            cpu_instr = data_rdata;
          end else begin
            cpu_stall = 1'b1;
            w_next    = ST_MEM_REQ;
          end
        end
      end
      ST_MEM_REQ: begin
        ram_index = r_index;
        mem_req   = 1'b1;
        mem_addr  = {r_tag, r_index, 2'b00};
        cpu_stall = 1'b1;
        if (mem_ack) begin
          w_next = ST_FILL;
        end
      end
      ST_FILL: begin
        ram_index   = r_index;
        ram_write   = 1'b1;
        tag_wdata   = r_tag;
        valid_wdata = 1'b1;
        data_wdata  = r_fill;
        cpu_stall   = 1'b1;
        w_next      = ST_RESUME;
      end
      ST_RESUME: begin
        ram_index = r_index;
        cpu_instr = r_fill;
        w_next    = ST_LOOKUP;
      end
`ifdef ICACHE_FLUSH_EN
      ST_FLUSH: begin
        ram_index = w_flush_idx;
        ram_write = ~r_flush_cnt[0];
        cpu_stall = 1'b1;
        if (&r_flush_cnt) begin
          w_next = ST_LOOKUP;
        end
      end
`endif
      default: begin
        w_next = ST_LOOKUP;
      end
    endcase
    // Outputs read as idle for as long as reset is held.
    if (!rst_n) begin
      cpu_stall   = 1'b0;
      cpu_instr   = '0;
      mem_req     = 1'b0;
      mem_addr    = '0;
      ram_index   = '0;
      ram_write   = 1'b0;
      tag_wdata   = '0;
      valid_wdata = 1'b0;
      data_wdata  = '0;
    end
  end

endmodule
